seq_detect_ctrl: RTL and testbench
==================================

// Module: seq_detect_ctrl
// PURPOSE
//  Byte-fed controller for the serial sequence-detector path.
//  - Accepts a programmed number of bytes over a valid/ready port.
//  - Serialises each byte MSB-first, one bit per clk, into a PAT_W-bit pattern matcher.
//  - Raises a 1-cycle z pulse per match and counts matches.
//  - Reports busy/done so a host can run repeated scans on one shared detector.
// PARAMETERS
//  PAT_W   4   pattern length in bits (2..8)
//  CNT_W   8   width of match counter
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-low reset
//  start      in   1       begin scan; sampled in IDLE only
//  pattern    in   PAT_W   target sequence, MSB = oldest bit; latched on start
//  overlap    in   1       1 = overlapping matches, 0 = non-overlapping; latched on start
//  num_bytes  in   8       bytes to scan; latched on start
//  in_valid   in   1       byte available
//  in_data    in   8       byte payload
//  in_ready   out  1       controller accepts byte this cycle
//  z          out  1       match pulse, 1 cycle
//  match_cnt  out  CNT_W   matches this scan, saturating
//  busy       out  1       scan in progress (not IDLE)
//  done       out  1       1-cycle pulse, scan complete
// BEHAVIOUR
//  - Clock/reset: one clock; reset is synchronous and active-low.
//  - Reset (reset==0 at clk edge, also mid-scan): state=IDLE; in_ready, z, busy, done=0;
//    match_cnt=0; history/fill/bit/byte counters=0. No partial-byte state survives.
//  - FSM:
//    - IDLE: busy=0.
//      - start=1 latches pattern/overlap/num_bytes, clears match_cnt/history/fill.
//      - Then goes to LOAD, or to DONE if num_bytes==0.
//    - LOAD: in_ready=1. in_valid&in_ready captures in_data, sets bit_idx=7, goes to SHIFT.
//      Stays in LOAD with no in_valid.
//    - SHIFT: in_ready=0; each cycle hist<={hist[PAT_W-2:0],byte[bit_idx]}, fill=min(fill+1,PAT_W).
//      - After bit_idx==0: decrement bytes_left; go to LOAD if nonzero, else DONE.
//    - DONE: done=1 for exactly one cycle, busy=1; next state IDLE.
//  - Match: in a SHIFT cycle where new fill==PAT_W and new hist==pattern:
//    - z=1 the following cycle; match_cnt increments on that same edge.
//    - z is registered: latency 1 clk after the completing bit shifts.
//    - overlap=0: fill cleared to 0 on match, so the next match needs PAT_W fresh bits.
//    - overlap=1: fill stays PAT_W.
//  - History and fill persist across byte boundaries, so patterns may straddle bytes.
//  - Throughput: 9 clk per byte minimum (1 LOAD + 8 SHIFT); extra LOAD cycles while in_valid=0.
//  - match_cnt saturates at 2^CNT_W-1; z still pulses at saturation.
//  - match_cnt holds after DONE until the next accepted start.
//  - start while busy: ignored. start in the same cycle done pulses: ignored (state is DONE).
//  - A match on the final bit gives z=1 in the DONE cycle, coincident with done.
// CONFIGURATION
//  SEQ_DETECT_CTRL_ABORT_EN defined:
//   - Adds input port abort (1 bit).
//   - abort=1 in LOAD or SHIFT: next state DONE; the current byte is discarded.
//   - match_cnt keeps the count at abort; a pending z from the prior cycle still fires.
//   - abort is ignored in IDLE and DONE.
//  Macro not defined: no abort port; a scan only ends after num_bytes bytes or on reset.
// TESTING
//  - Reset: hold reset=0 2 clk mid-SHIFT -> all outputs 0, IDLE; start next cycle runs normally.
//  - PAT_W=4, pattern=4'b1011, 1 byte 8'hBB -> z pulses 5 and 9 clk after byte accept;
//    match_cnt=2; done 1 clk after last bit.
//  - pattern=4'b1010, byte 8'hAA: overlap=1 -> match_cnt=3; overlap=0 -> match_cnt=2.
//  - Straddle: pattern=4'b1011, bytes 8'h01 then 8'h60 -> exactly 1 z, during byte 2
//    (3rd bit); match_cnt=1.
//  - Backpressure/zero-length: in_valid low 5 clk in LOAD -> in_ready held, no shift,
//    result unchanged. num_bytes=0 -> done 1 clk after start, match_cnt=0.
//  - CNT_W=2, 5 matching bytes -> match_cnt sticks at 3; z still pulses.
//    With ABORT_EN: abort in SHIFT -> done next clk, count preserved.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Byte-fed controller that serialises bytes MSB-first into a PAT_W-bit sequence matcher.
// Define SEQ_DETECT_CTRL_ABORT_EN to add the abort input; default build has no abort port.
module seq_detect_ctrl #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic             overlap,
   input  logic [7:0]       num_bytes,
`ifdef SEQ_DETECT_CTRL_ABORT_EN
   input  logic             abort,
`endif
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   localparam logic [3:0] FULL = 4'(PAT_W);

   state_t           state;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] hist;
   logic [PAT_W-1:0] hist_nxt;
   logic             ovl_q;
   logic [7:0]       bytes_left;
   logic [7:0]       byte_q;
   logic [2:0]       bit_idx;
   logic [3:0]       fill;
   logic [3:0]       fill_nxt;
   logic             hit;
   logic             abort_req;

   // Match is judged on the post-shift history so z can be registered on the same edge.
   always_comb begin
      hist_nxt = {hist[PAT_W-2:0], byte_q[bit_idx]};
      fill_nxt = (fill == FULL) ? FULL : fill + 4'd1;
      hit      = (fill_nxt == FULL) && (hist_nxt == pat_q);
   end

`ifdef SEQ_DETECT_CTRL_ABORT_EN
   always_comb abort_req = abort;
`else
   always_comb abort_req = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         pat_q      <= '0;
         ovl_q      <= 1'b0;
         bytes_left <= '0;
         byte_q     <= '0;
         bit_idx    <= '0;
         hist       <= '0;
         fill       <= '0;
         in_ready   <= 1'b0;
         z          <= 1'b0;
         match_cnt  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         z    <= 1'b0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pat_q      <= pattern;
                  ovl_q      <= overlap;
                  bytes_left <= num_bytes;
                  match_cnt  <= '0;
                  hist       <= '0;
                  fill       <= '0;
                  busy       <= 1'b1;
                  if (num_bytes == 8'd0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (abort_req) begin
                  state    <= DONE;
                  in_ready <= 1'b0;
                  done     <= 1'b1;
               end else if (in_valid) begin
                  byte_q   <= in_data;
                  bit_idx  <= 3'd7;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (abort_req) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  hist <= hist_nxt;
                  fill <= (hit && !ovl_q) ? 4'd0 : fill_nxt;
                  if (hit) begin
                     z <= 1'b1;
                     if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
                  end
                  if (bit_idx == 3'd0) begin
                     bytes_left <= bytes_left - 8'd1;
                     if (bytes_left == 8'd1) begin
                        state <= DONE;
                        done  <= 1'b1;
                     end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                     end
                  end else begin
                     bit_idx <= bit_idx - 3'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl (PAT_W=4, CNT_W=2): expected z/done events are queued
// with their cycle and count; a negedge monitor pops and compares them.
module tb_seq_detect_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] pattern;
   logic       overlap;
   logic [7:0] num_bytes;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       z;
   logic [1:0] match_cnt;
   logic       busy;
   logic       done;
`ifdef SEQ_DETECT_CTRL_ABORT_EN
   logic       abort;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      bit is_done;
      int cyc;
      int cnt;
   } ev_t;

   ev_t sb[$];

   seq_detect_ctrl #(.PAT_W(4), .CNT_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pattern   (pattern),
      .overlap   (overlap),
      .num_bytes (num_bytes),
`ifdef SEQ_DETECT_CTRL_ABORT_EN
      .abort     (abort),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .z         (z),
      .match_cnt (match_cnt),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_ev(input bit is_done, input int c, input int n);
      ev_t e;
      e.is_done = is_done;
      e.cyc     = c;
      e.cnt     = n;
      sb.push_back(e);
   endtask

   task automatic pop_check(input bit is_done);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: cycle %0d cnt %0d, no event expected",
                  is_done ? "done" : "z", cyc, match_cnt);
      end else begin
         e = sb.pop_front();
         if (e.is_done != is_done || e.cyc != cyc || e.cnt != int'(match_cnt)) begin
            errors++;
            $display("FAIL event_%s: got done=%0d cycle=%0d cnt=%0d, expected done=%0d cycle=%0d cnt=%0d",
                     is_done ? "done" : "z", is_done, cyc, match_cnt, e.is_done, e.cyc, e.cnt);
         end
      end
   endtask

   always @(negedge clk) begin
      if (z)    pop_check(1'b0);
      if (done) pop_check(1'b1);
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic do_start(input logic [3:0] p, input logic ov, input logic [7:0] n, output int s);
      pattern   = p;
      overlap   = ov;
      num_bytes = n;
      start     = 1'b1;
      s         = cyc;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d);
      int t;
      t        = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && t < 40) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0 after %0d cycles, expected 1", t);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 100; i++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s_idle_timeout: busy got 1, expected 0", name);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      ev_t e;
      reset     = 1'b0;
      start     = 1'b0;
      pattern   = '0;
      overlap   = 1'b0;
      num_bytes = '0;
      in_valid  = 1'b0;
      in_data   = '0;
`ifdef SEQ_DETECT_CTRL_ABORT_EN
      abort     = 1'b0;
`endif
      repeat (2) @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_z", z, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", match_cnt, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // 1011 overlapping, byte BB: matches on bits 4 and 8
      do_start(4'b1011, 1'b1, 8'd1, s);
      push_ev(0, s + 6, 1);
      push_ev(0, s + 10, 2);
      push_ev(1, s + 10, 2);
      send_byte(8'hBB);
      wait_idle("bb");
      chk("bb_cnt_hold", match_cnt, 2);

      // 1010 overlapping, byte AA: 3 matches; a start mid-scan must be ignored
      do_start(4'b1010, 1'b1, 8'd1, s);
      push_ev(0, s + 6, 1);
      push_ev(0, s + 8, 2);
      push_ev(0, s + 10, 3);
      push_ev(1, s + 10, 3);
      send_byte(8'hAA);
      start = 1'b1; pattern = 4'b0000; num_bytes = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("aa_ov");
      chk("aa_ov_cnt_hold", match_cnt, 3);

      // 1010 non-overlapping: 2 matches; start during the done cycle is ignored
      do_start(4'b1010, 1'b0, 8'd1, s);
      push_ev(0, s + 6, 1);
      push_ev(0, s + 10, 2);
      push_ev(1, s + 10, 2);
      send_byte(8'hAA);
      repeat (8) @(posedge clk); #1;
      chk("aa_nov_done_cycle", done, 1);
      start = 1'b1; num_bytes = 8'd0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("aa_nov");
      repeat (3) @(posedge clk); #1;
      chk("start_in_done_busy", busy, 0);
      chk("aa_nov_cnt_hold", match_cnt, 2);

      // pattern straddling a byte boundary
      do_start(4'b1011, 1'b1, 8'd2, s);
      push_ev(0, s + 14, 1);
      push_ev(1, s + 19, 1);
      send_byte(8'h01);
      send_byte(8'h60);
      wait_idle("straddle");
      chk("straddle_cnt", match_cnt, 1);

      // backpressure: in_valid low for 5 LOAD cycles
      do_start(4'b1011, 1'b1, 8'd1, s);
      push_ev(0, s + 11, 1);
      push_ev(0, s + 15, 2);
      push_ev(1, s + 15, 2);
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", in_ready, 1);
         chk("bp_cnt", match_cnt, 0);
         @(posedge clk); #1;
      end
      send_byte(8'hBB);
      wait_idle("bp");
      chk("bp_cnt_hold", match_cnt, 2);

      // zero-length scan
      do_start(4'b1011, 1'b1, 8'd0, s);
      push_ev(1, s + 1, 0);
      chk("zero_cnt_cleared", match_cnt, 0);
      wait_idle("zero");

      // reset held 2 clk mid-SHIFT, then an immediate normal scan
      do_start(4'b1011, 1'b1, 8'd1, s);
      send_byte(8'hBB);
      reset = 1'b0;
      repeat (2) @(posedge clk); #1;
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_z", z, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_cnt", match_cnt, 0);
      reset = 1'b1;
      do_start(4'b1011, 1'b1, 8'd1, s);
      push_ev(0, s + 6, 1);
      push_ev(0, s + 10, 2);
      push_ev(1, s + 10, 2);
      send_byte(8'hBB);
      wait_idle("post_rst");
      chk("post_rst_cnt", match_cnt, 2);

      // saturation: 5 x BB gives 10 matches, 2-bit counter sticks at 3
      do_start(4'b1011, 1'b1, 8'd5, s);
      for (int b = 0; b < 5; b++) begin
         push_ev(0, s + 6 + 9 * b, (2 * b + 1 > 3) ? 3 : 2 * b + 1);
         push_ev(0, s + 10 + 9 * b, (2 * b + 2 > 3) ? 3 : 2 * b + 2);
      end
      push_ev(1, s + 46, 3);
      for (int b = 0; b < 5; b++) send_byte(8'hBB);
      wait_idle("sat");
      chk("sat_cnt", match_cnt, 3);

`ifdef SEQ_DETECT_CTRL_ABORT_EN
      // abort mid-SHIFT after the first match
      do_start(4'b1011, 1'b1, 8'd1, s);
      push_ev(0, s + 6, 1);
      push_ev(1, s + 8, 1);
      send_byte(8'hBB);
      repeat (5) @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_idle("abort");
      chk("abort_cnt", match_cnt, 1);
`endif

      repeat (5) @(posedge clk); #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_event: got none, expected done=%0d cycle=%0d cnt=%0d",
                  e.is_done, e.cyc, e.cnt);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
